call_ctrl: RTL

Control-flow stage that sits directly upstream of the program counter and drives its `jump_code`, `jump_address` and `return_address` inputs. It decodes the current instruction's control-flow op into a PC command and keeps a hardware return-address stack for CALL/RET. It also runs a post-reset init sequence that forces the PC to address 0, because the PC itself has no reset. It detects stack overflow and underflow and freezes the PC when either occurs.

---
 rtl/puc_pkg.sv | 11 +
 rtl/ret_stack.sv | 37 +++
 rtl/call_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/puc_pkg.sv
// puc_pkg: shared PC command, control-flow op and call FSM types
package puc_pkg;
  typedef enum logic [4:0] {
    JC_RESET = 5'd0,
    JC_JUMP  = 5'd1,
    JC_RET   = 5'd2,
    JC_NEXT  = 5'd3
  } jump_code_t;
  typedef enum logic [1:0] {OP_NONE, OP_JUMP, OP_CALL, OP_RET} cf_op_t;
  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FAULT} call_state_t;
endpackage

// File: rtl/ret_stack.sv
// ret_stack: return-address LIFO that ignores push when full and pop when empty
module ret_stack #(
  parameter int W     = 5,
  parameter int DEPTH = 4,
  localparam int DW   = $clog2(DEPTH + 1),
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  top_o,
  output logic [DW-1:0] depth_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [DW-1:0] ptr_q;
  logic [AW-1:0] top_idx;
  assign full_o  = ptr_q == DW'(DEPTH);
  assign empty_o = ptr_q == '0;
  assign depth_o = ptr_q;
  assign top_idx = AW'(ptr_q - DW'(1));
  assign top_o   = empty_o ? '0 : mem_q[top_idx];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
      ptr_q <= '0;
    end else if (push_i && !full_o) begin
      mem_q[AW'(ptr_q)] <= data_i;
      ptr_q             <= ptr_q + DW'(1);
    end else if (pop_i && !empty_o) begin
      ptr_q <= ptr_q - DW'(1);
    end
  end
endmodule

// File: rtl/call_ctrl.sv
// call_ctrl: decodes control-flow ops into PC commands, owns the return stack
module call_ctrl
  import puc_pkg::*;
#(
  parameter int INSTR_ADDR_SIZE = 5,
  parameter int STACK_DEPTH     = 4,
  parameter int INIT_CYCLES     = 2,
  localparam int DW             = $clog2(STACK_DEPTH + 1),
  localparam int CW             = $clog2(INIT_CYCLES + 1)
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       stall,
  input  logic [1:0]                 op,
  input  logic                       cond_en,
  input  logic                       cond,
  input  logic [INSTR_ADDR_SIZE-1:0] target,
  input  logic [INSTR_ADDR_SIZE-1:0] instruction_address,
  output jump_code_t                 jump_code,
  output logic [INSTR_ADDR_SIZE-1:0] jump_address,
  output logic [INSTR_ADDR_SIZE-1:0] return_address,
  output logic [DW-1:0]              depth,
  output logic                       overflow,
  output logic                       underflow
);
  call_state_t                state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       ovf_q, ovf_d, unf_q, unf_d;
  logic                       push, pop, full, empty;
  logic [INSTR_ADDR_SIZE-1:0] ja;
  cf_op_t                     op_t;
  assign op_t      = cf_op_t'(op);
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  ret_stack #(.W(INSTR_ADDR_SIZE), .DEPTH(STACK_DEPTH)) u_stack (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (instruction_address + INSTR_ADDR_SIZE'(1)),
    .top_o   (return_address),
    .depth_o (depth),
    .full_o  (full),
    .empty_o (empty)
  );
  // Holding the PC is a JUMP to the current address; FAULT relies on this default.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    push      = 1'b0;
    pop       = 1'b0;
    jump_code = JC_JUMP;
    ja        = instruction_address;
    case (state_q)
      ST_INIT: begin
        jump_code = JC_RESET;
        cnt_d     = cnt_q + CW'(1);
        state_d   = (cnt_q == CW'(INIT_CYCLES - 1)) ? ST_RUN : ST_INIT;
      end
      ST_RUN: if (!stall) begin
        case (op_t)
          OP_NONE: jump_code = JC_NEXT;
          OP_JUMP: begin
            jump_code = (!cond_en || cond) ? JC_JUMP : JC_NEXT;
            ja        = target;
          end
          OP_CALL: begin
            push    = !full;
            ja      = full ? instruction_address : target;
            ovf_d   = ovf_q | full;
            state_d = full ? ST_FAULT : ST_RUN;
          end
          OP_RET: begin
            pop       = !empty;
            jump_code = empty ? JC_JUMP : JC_RET;
            unf_d     = unf_q | empty;
            state_d   = empty ? ST_FAULT : ST_RUN;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end
  assign jump_address = (jump_code == JC_JUMP) ? ja : '0;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
endmodule
